// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32 instruction encoder.
// The master side produces requests and consumes encoded words; the slave side is the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_last, err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_last, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs raw RV32 fields into instruction words; expands the LI pseudo-op into
// ADDI, LUI, or LUI+ADDI with a one-word output register and valid/ready flow control.
//
// state  | meaning
// IDLE   | accepting requests; output register may hold a word
// SECOND | LUI of a two-word LI is held; ADDI loads once LUI is consumed
module instr_encoder (
  input  logic          clk,
  input  logic          rst,
  instr_encoder_if.slave bus
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      r_state;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic        r_out_last;
  logic        r_err;
  logic [31:0] r_pend;

  logic        w_accept;
  logic        w_consume;
  logic        w_illegal;
  logic        w_fits;
  logic [19:0] w_hi;
  logic [31:0] w_word;
  logic        w_last;
  logic        w_two;
  logic [31:0] w_addi2;

  assign bus.in_ready  = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_last  = r_out_last;
  assign bus.err       = r_err;

  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_consume = r_out_valid && bus.out_ready;
  assign w_illegal = (bus.in_fmt == 3'd7);

  // Immediate fits ADDI when bits 31:11 are all copies of bit 11.
  assign w_fits  = (bus.in_imm[31:11] == {21{bus.in_imm[11]}});
  // Upper part rounded so that the sign-extended ADDI low part lands on imm.
  assign w_hi    = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};
  assign w_addi2 = {bus.in_imm[11:0], bus.in_rd, 3'b000, bus.in_rd, 7'b0010011};

  always_comb begin
    w_word = 32'd0;
    w_last = 1'b1;
    w_two  = 1'b0;
    case (bus.in_fmt)
      3'd0: w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd1: w_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd2: w_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                      bus.in_imm[4:0], bus.in_opcode};
      3'd3: w_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                      bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
      3'd4: w_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
      3'd5: w_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                      bus.in_rd, bus.in_opcode};
      3'd6: begin
        if (w_fits) begin
          w_word = {bus.in_imm[11:0], 5'd0, 3'b000, bus.in_rd, 7'b0010011};
        end else begin
          w_word = {w_hi, bus.in_rd, 7'b0110111};
          if (bus.in_imm[11:0] != 12'd0) begin
            w_two  = 1'b1;
            w_last = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_pend      <= 32'd0;
    end else begin
      r_err <= w_accept && w_illegal;
      case (r_state)
        IDLE: begin
          if (w_accept && !w_illegal) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_word;
            r_out_last  <= w_last;
            if (w_two) begin
              r_pend  <= w_addi2;
              r_state <= SECOND;
            end
          end else if (w_consume) begin
            r_out_valid <= 1'b0;
          end
        end
        SECOND: begin
          if (w_consume) begin
            r_out_valid <= 1'b1;
            r_out_instr <= r_pend;
            r_out_last  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed spec vectors plus randomized
// traffic compared against an arithmetic reference model and an expected-word queue.
module tb_instr_encoder;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  logic clk;
  logic rst;
  instr_encoder_if bus ();

  instr_encoder dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] exp_q[$];
  logic [32:0] dir_q[$];
  logic        exp_err = 1'b0;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input logic last, input logic [31:0] w);
    exp_q.push_back({last, w});
  endfunction

  // Reference: plain shift/mask arithmetic on the field values.
  function automatic void model(input req_t r);
    logic [31:0] imm, op, rd, rs1, rs2, f3, f7, lo, sext, hi;
    imm = r.imm; op = 32'(r.op); rd = 32'(r.rd); rs1 = 32'(r.rs1);
    rs2 = 32'(r.rs2); f3 = 32'(r.f3); f7 = 32'(r.f7);
    case (r.fmt)
      3'd0: push(1'b1, (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
      3'd1: push(1'b1, ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
      3'd2: push(1'b1, (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                       | ((imm & 32'h1F) << 7) | op);
      3'd3: push(1'b1, (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                       | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                       | (((imm >> 11) & 1) << 7) | op);
      3'd4: push(1'b1, (imm & 32'hFFFFF000) | (rd << 7) | op);
      3'd5: push(1'b1, (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                       | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op);
      3'd6: begin
        lo   = imm & 32'hFFF;
        sext = (lo >= 32'h800) ? lo - 32'h1000 : lo;
        if (sext == imm) begin
          push(1'b1, (lo << 20) | (rd << 7) | 32'h13);
        end else begin
          hi = (imm + 32'h800) >> 12;
          push(lo == 0, (hi << 12) | (rd << 7) | 32'h37);
          if (lo != 0) push(1'b1, (lo << 20) | (rd << 15) | (rd << 7) | 32'h13);
        end
      end
      default: ;
    endcase
  endfunction

  // One cycle: drive at negedge, check settled outputs, update the model, advance.
  task automatic step(input logic v, input req_t r, input logic rdy, output logic acc);
    logic cons, nerr;
    bus.in_valid  = v;
    bus.in_fmt    = r.fmt;   bus.in_opcode = r.op;  bus.in_funct3 = r.f3;
    bus.in_funct7 = r.f7;    bus.in_rd     = r.rd;  bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;   bus.in_imm    = r.imm; bus.out_ready = rdy;
    #1;
    chk("err", 33'(bus.err), 33'(exp_err));
    chk("out_valid", 33'(bus.out_valid), 33'(exp_q.size() != 0));
    chk("in_ready", 33'(bus.in_ready), 33'(exp_q.size() == 0 || (exp_q.size() == 1 && rdy)));
    if (exp_q.size() != 0) chk("out_word", {bus.out_last, bus.out_instr}, exp_q[0]);
    acc  = v && bus.in_ready;
    cons = bus.out_valid && rdy;
    if (cons && exp_q.size() != 0) void'(exp_q.pop_front());
    nerr = acc && (r.fmt == 3'd7);
    if (acc) begin
      if (dir_q.size() != 0) begin
        foreach (dir_q[i]) exp_q.push_back(dir_q[i]);
        dir_q.delete();
      end else begin
        model(r);
      end
    end
    @(posedge clk);
    exp_err = nerr;
    @(negedge clk);
  endtask

  task automatic send(input req_t r, input logic rdy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, r, rdy, acc);
    if (!acc) chk("send_timeout", 33'd0, 33'd1);
  endtask

  task automatic idle(input int n, input logic rdy);
    logic acc;
    req_t z;
    z = '0;
    for (int i = 0; i < n; i++) step(1'b0, z, rdy, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1, 1'b1);
    if (exp_q.size() != 0) chk("drain_timeout", 33'(exp_q.size()), 33'd0);
  endtask

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    r.fmt = a[2:0]; r.op = a[9:3]; r.f3 = a[12:10]; r.f7 = a[19:13];
    r.rd = a[24:20]; r.rs1 = a[29:25]; r.rs2 = b[4:0];
    case ($urandom_range(0, 5))
      0: r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: case ($urandom_range(0, 4))
           0: r.imm = 32'hFFFFF800;
           1: r.imm = 32'h000007FF;
           2: r.imm = 32'h00000800;
           3: r.imm = 32'hFFFFF7FF;
           default: r.imm = 32'h00000FFF;
         endcase
      2: r.imm = $urandom & 32'hFFFFF000;
      default: r.imm = $urandom;
    endcase
    return r;
  endfunction

  initial begin
    logic acc;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_fmt = '0; bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
    bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    @(negedge clk);
    #1;
    chk("rst_valid", 33'(bus.out_valid), 33'd0);
    chk("rst_word", {bus.out_last, bus.out_instr}, 33'd0);
    chk("rst_err", 33'(bus.err), 33'd0);
    @(negedge clk);
    rst = 1'b0;

    // R-type and B-type reference words
    dir_q.push_back({1'b1, 32'h002081B3});
    send(mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0), 1'b1);
    dir_q.push_back({1'b1, 32'hFE208EE3});
    send(mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC), 1'b1);
    drain();

    // Two-word LI with a blocked request while the ADDI is still owed
    dir_q.push_back({1'b0, 32'h123452B7});
    dir_q.push_back({1'b1, 32'h67828293});
    send(mk(3'd6, 7'h7F, 3'd7, 7'h7F, 5'd5, 5'd9, 5'd9, 32'h12345678), 1'b1);
    step(1'b1, mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0), 1'b0, acc);
    chk("second_no_accept", 33'(acc), 33'd0);
    drain();

    // LI boundaries
    dir_q.push_back({1'b1, 32'h80000093});
    send(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800), 1'b1);
    dir_q.push_back({1'b1, 32'h00001137});
    send(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h00001000), 1'b1);
    dir_q.push_back({1'b0, 32'h000010B7});
    dir_q.push_back({1'b1, 32'hFFF08093});
    send(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000FFF), 1'b1);
    drain();

    // Backpressure: three stalled cycles, then release
    send(mk(3'd1, 7'h13, 3'd2, 7'd0, 5'd7, 5'd8, 5'd0, 32'h00000ABC), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hABCDE000), 1'b0, acc);
      chk("stall_no_accept", 33'(acc), 33'd0);
    end
    send(mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hABCDE000), 1'b1);
    drain();

    // Illegal format: err pulse, no word
    send(mk(3'd7, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0), 1'b1);
    idle(3, 1'b1);

    // Reset while the ADDI of an LI is pending and output is stalled
    send(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678), 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 33'(bus.out_valid), 33'd0);
    chk("async_rst_word", {bus.out_last, bus.out_instr}, 33'd0);
    exp_q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(4, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 2) != 0), rnd_req(), ($urandom_range(0, 3) != 0), acc);
    end
    drain();
    idle(2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port: in_valid  input  1  request present.
REQ-004 SHALL have port: in_ready  output  1  request accepted when in_valid&&in_ready at clk edge.
REQ-005 SHALL have port: in_fmt  input  3  0=R,1=I,2=S,3=B,4=U,5=J,6=LI pseudo-op,7=illegal.
REQ-006 SHALL have ports: in_opcode 7, in_funct3 3, in_funct7 7, in_rd 5, in_rs1 5, in_rs2 5, in_imm 32, all inputs, raw field values.
REQ-007 SHALL have port: out_valid  output  1  out_instr holds a word.
REQ-008 SHALL have port: out_ready  input  1  consumer takes word when out_valid&&out_ready.
REQ-009 SHALL have port: out_instr  output  32  encoded RV32 instruction word.
REQ-010 SHALL have port: out_last  output  1  final word of the current request.
REQ-011 SHALL have port: err  output  1  one-cycle pulse on acceptance of in_fmt=7.

Function
REQ-012 SHALL compute in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-013 SHALL register output words: word appears on out_instr the cycle after acceptance (latency 1).
REQ-014 SHALL hold out_instr/out_last stable while out_valid && !out_ready.
REQ-015 SHALL clear out_valid after consumption unless a new word loads the same edge (back-to-back full throughput).
REQ-016 SHALL encode R: funct7|rs2|rs1|funct3|rd|opcode.
REQ-017 SHALL encode I: imm[11:0]|rs1|funct3|rd|opcode.
REQ-018 SHALL encode S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-019 SHALL encode B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode; imm[0] ignored.
REQ-020 SHALL encode U: imm[31:12]|rd|opcode.
REQ-021 SHALL encode J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode; imm[0] ignored.
REQ-022 SHALL pass in_opcode through unmodified for fmt 0-5; ignore unused fields per format.
REQ-023 SHALL expand LI (fmt 6; opcode/funct/rs ignored): if imm sign-extends from 12 bits, emit single ADDI rd,x0,imm[11:0] (opcode 0010011, funct3 000), out_last=1.
REQ-024 SHALL otherwise emit LUI rd,hi (opcode 0110111) with hi=(imm+0x800)[31:12] (32-bit wrap), then ADDI rd,rd,imm[11:0].
REQ-025 SHALL omit the ADDI when imm[11:0]==0; LUI then carries out_last=1.
REQ-026 SHALL use FSM IDLE/SECOND: IDLE->SECOND when a two-word LI loads LUI (out_last=0); SECOND loads ADDI (out_last=1) when LUI consumed, ->IDLE; in_ready=0 throughout SECOND.
REQ-027 SHALL, on fmt 7 acceptance, pulse err next cycle, produce no output word, remain IDLE.
REQ-028 SHALL give out_last=1 for every fmt 0-5 word.

Reset
REQ-029 SHALL, on rst assertion (any state, incl. SECOND or stalled output), asynchronously force out_valid=0, out_last=0, out_instr=0, err=0, state=IDLE; pending ADDI discarded.
REQ-030 SHALL present in_ready=1 the first cycle after rst deasserts.

Verification
REQ-031 SHALL cover R: fmt0, funct7=0,rs2=2,rs1=1,funct3=0,rd=3,opcode=0x33 -> 0x002081B3, last=1.
REQ-032 SHALL cover B: fmt3, rs1=1,rs2=2,funct3=0,opcode=0x63,imm=0xFFFFFFFC -> 0xFE208EE3.
REQ-033 SHALL cover LI rd=5, imm=0x12345678 -> 0x123452B7 (last=0) then 0x67828293 (last=1); in_ready=0 between.
REQ-034 SHALL cover LI boundaries: rd=1,imm=0xFFFFF800 -> 0x80000093 single; rd=2,imm=0x1000 -> 0x00001137 single; rd=1,imm=0xFFF -> 0x000010B7 then 0xFFF08093.
REQ-035 SHALL cover backpressure: out_ready=0 for 3 cycles -> out_instr stable, in_ready=0; release -> next word following cycle, no loss/duplication.
REQ-036 SHALL cover rst asserted in SECOND -> out_valid=0 immediately, no ADDI emitted after release; fmt7 -> err pulse, out_valid stays 0.
